// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encoding (IDLE, CALC, DONE), 2 bits
//   OPW     : operand width
//   PW      : product width
//   NSTEP   : number of CALC cycles per multiply
package shift_add_mult_pkg;

    localparam int unsigned OPW   = 4;
    localparam int unsigned PW    = 8;
    localparam int unsigned NSTEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_ripple.sv
// 4-bit ripple-carry add/subtract stage.
//   m    : mode, 0 = add (a + b), 1 = subtract (a - b, two's complement)
//   a, b : operands
//   s    : sum / difference
//   cout : carry-out of the top bit
module ripple
    import shift_add_mult_pkg::*;
(
    input  logic           m,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] s,
    output logic           cout
);

    always_comb begin
        logic [OPW:0]   c;
        logic [OPW-1:0] bx;
        // Subtract is a + ~b + 1: invert b and feed the mode in as carry-in.
        bx   = b ^ {OPW{m}};
        c    = '0;
        c[0] = m;
        s    = '0;
        for (int unsigned i = 0; i < OPW; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        cout = c[OPW];
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   a, b  : multiplicand / multiplier, captured when start is accepted
//   busy  : high while the four CALC cycles run
//   done  : one-cycle pulse when p is updated
//   p     : registered product, held until the next completion
module shift_add_mult
    import shift_add_mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [PW-1:0]  p
);

    localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

    state_t         state;
    logic [OPW-1:0] mcand;
    logic [OPW-1:0] acc;
    logic [OPW-1:0] q;
    logic [1:0]     cnt;

    logic [OPW-1:0] addend;
    logic [OPW-1:0] sum;
    logic           carry;

    assign addend = q[0] ? mcand : '0;

    ripple u_adder (
        .m    (1'b0),
        .a    (acc),
        .b    (addend),
        .s    (sum),
        .cout (carry)
    );

    // busy/done are registered alongside state so they always equal
    // (state == CALC) and (state == DONE) without a combinational decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    // {acc,q} shifts right one place with the adder carry on top.
                    acc <= {carry, sum[OPW-1:1]};
                    q   <= {sum[0], q[OPW-1:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_STEP) begin
                        // Final {acc,q} after this shift, taken straight from the adder.
                        p     <= {carry, sum, q[OPW-1:1]};
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int errors = 0;
    int checks = 0;

    shift_add_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference product: plain integer multiply.
    function automatic int ref_mul(input logic [3:0] x, input logic [3:0] y);
        return int'(x) * int'(y);
    endfunction

    // One operation: accept, observe latency/busy, compare product, check pulse width.
    // With scramble set, a/b/start are randomised while the operation is in flight.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input int exp_p, input string tag, input bit scramble);
        int  lat;
        int  busy_cycles;
        bit  seen;
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (scramble) begin
                    a = 4'($urandom);
                    b = 4'($urandom);
                    start = 1'($urandom);
                end
                step();
                lat++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, " timeout"}, 0, 1);
        end else begin
            check({tag, " latency"}, lat, 4);
            check({tag, " busy_cycles"}, busy_cycles, 4);
            check({tag, " p"}, int'(p), exp_p);
            step();
            check({tag, " done_width"}, int'(done), 0);
        end
    endtask

    initial begin
        int n_done;
        int got_p;
        int d_idx[$];
        int d_p[$];

        vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
        vecs[1] = '{a: 4'd9,  b: 4'd0,  p: 8'h00};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        vecs[4] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
        vecs[5] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
        vecs[6] = '{a: 4'd8,  b: 4'd8,  p: 8'd64};
        vecs[7] = '{a: 4'd10, b: 4'd13, p: 8'd130};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset p", int'(p), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, int'(vecs[i].p), $sformatf("vec%0d", i), 1'b0);
            step();
        end

        // Operand change and start pulse mid-calculation must not disturb 6*7.
        a = 4'd6;
        b = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        got_p = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                n_done++;
                got_p = int'(p);
            end
            step();
        end
        check("inflight done_count", n_done, 1);
        check("inflight p", got_p, 42);

        // start held high: back-to-back operations every 6 cycles.
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done) begin
                d_idx.push_back(i);
                d_p.push_back(int'(p));
            end
            if (i == 1) begin
                a = 4'd12;
                b = 4'd11;
            end
            if (i == 6) start = 1'b0;
        end
        check("held done_count", d_idx.size(), 2);
        if (d_idx.size() == 2) begin
            check("held first_done_at", d_idx[0], 4);
            check("held spacing", d_idx[1] - d_idx[0], 6);
            check("held p0", d_p[0], 15);
            check("held p1", d_p[1], 132);
        end

        // Reset during the 3rd CALC cycle aborts the operation.
        a = 4'd15;
        b = 4'd15;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort pre busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort p", int'(p), 0);
        step();
        step();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) n_done++;
            step();
        end
        check("abort no_done", n_done, 0);
        check("abort p_hold", int'(p), 0);
        run_op(4'd2, 4'd3, 6, "post_reset", 1'b0);

        // Immediate accept on the first edge after reset release.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_op(4'd4, 4'd5, 20, "first_after_release", 1'b0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(i);
            run_op(pair[7:4], pair[3:0], ref_mul(pair[7:4], pair[3:0]),
                   $sformatf("sweep_%0d_%0d", pair[7:4], pair[3:0]), 1'b0);
        end

        for (int i = 0; i < 100; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            int gap;
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand_%0d_%0d", ra, rb), 1'b1);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
